// File: rtl/alu_control_pipe.sv
// alu_control_pipe: turns an ALUop / one-hot function code request into a
// registered ALU control code, using a valid/ready handshake on each side.
// ALUop 3'b111 is a multi-cycle class whose result appears MC_CYCLES cycles
// after it is accepted.
// Build option: define ALU_CTRL_ILLEGAL_TRAP_EN to drive the illegal flag.
// Without it, illegal is tied low and unlisted encodings decode silently to 0.
//
// state | meaning
// IDLE  | output register empty, ready for a request
// HOLD  | output register holds a valid result until it is consumed
// MULTI | multi-cycle op in flight, counting down to its result
module alu_control_pipe #(
    parameter int OP_W      = 3,
    parameter int FUNC_W    = 5,
    parameter int CTRL_W    = 5,
    parameter int MC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   ALUop,
    input  logic [FUNC_W-1:0] function_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALU_control_signal,
    output logic              illegal
);

    localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        MULTI = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CTRL_W-1:0] code_q, code_nxt;
    logic              illegal_q, illegal_nxt;

    logic [2:0]        op_lo;
    logic [4:0]        func_lo;
    logic              op_hi_zero;
    logic              func_hi_zero;
    logic [4:0]        dec_code;
    logic              dec_illegal;
    logic              dec_multi;
    logic              accept;

    assign op_lo        = ALUop[2:0];
    assign func_lo      = function_code[4:0];
    assign op_hi_zero   = ((ALUop >> 3) == '0);
    assign func_hi_zero = ((function_code >> 5) == '0);

    // Decode the request into a 5-bit code; unlisted function codes give 0.
    always_comb begin
        dec_code    = 5'd0;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        if (!op_hi_zero) begin
            dec_illegal = 1'b1;
        end else begin
            case (op_lo)
                3'b000: dec_code = 5'd0;
                3'b001: begin
                    case ({func_hi_zero, func_lo})
                        6'b1_00001: dec_code = 5'd1;
                        6'b1_00010: dec_code = 5'd2;
                        6'b1_00100: dec_code = 5'd3;
                        6'b1_01000: dec_code = 5'd4;
                        6'b1_10000: dec_code = 5'd5;
                        default:    dec_illegal = 1'b1;
                    endcase
                end
                3'b010: begin
                    case ({func_hi_zero, func_lo})
                        6'b1_00001: dec_code = 5'd6;
                        6'b1_00010: dec_code = 5'd7;
                        6'b1_00100: dec_code = 5'd8;
                        default:    dec_illegal = 1'b1;
                    endcase
                end
                3'b011: begin
                    case ({func_hi_zero, func_lo})
                        6'b1_00001: dec_code = 5'd9;
                        6'b1_00010: dec_code = 5'd10;
                        6'b1_00100: dec_code = 5'd11;
                        default:    dec_illegal = 1'b1;
                    endcase
                end
                3'b100: begin
                    case ({func_hi_zero, func_lo})
                        6'b1_00001: dec_code = 5'd12;
                        6'b1_00010: dec_code = 5'd13;
                        default:    dec_illegal = 1'b1;
                    endcase
                end
                3'b101: begin
                    case ({func_hi_zero, func_lo})
                        6'b1_00001: dec_code = 5'd14;
                        6'b1_00010: dec_code = 5'd15;
                        6'b1_00100: dec_code = 5'd16;
                        default:    dec_illegal = 1'b1;
                    endcase
                end
                3'b110: dec_code = 5'd17;
                default: begin
                    dec_code  = 5'd18;
                    dec_multi = 1'b1;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    // Next-state, countdown and output-register load.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        code_nxt    = code_q;
        illegal_nxt = illegal_q;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    // MC_CYCLES == 1 collapses the multi-cycle class into a
                    // plain single-cycle op.
                    if (dec_multi && (MC_CYCLES > 1)) begin
                        state_nxt = MULTI;
                        cnt_nxt   = CNT_W'(MC_CYCLES - 1);
                    end else begin
                        state_nxt = HOLD;
                        code_nxt  = CTRL_W'(dec_code);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        illegal_nxt = dec_illegal;
`else
                        illegal_nxt = 1'b0;
`endif
                    end
                end else if (state == HOLD && out_ready) begin
                    // Result consumed with nothing behind it; keep the
                    // registers as they are.
                    state_nxt = IDLE;
                end
            end
            MULTI: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt   = HOLD;
                    cnt_nxt     = '0;
                    code_nxt    = CTRL_W'(5'd18);
                    illegal_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and result registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            code_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            code_q    <= code_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    assign ALU_control_signal = code_q;
    assign illegal            = illegal_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: directed scenarios plus a random
// phase, with expected results queued at each accepted request and compared
// when the result is handed over.
module tb_alu_control_pipe;

    localparam int OP_W      = 3;
    localparam int FUNC_W    = 5;
    localparam int CTRL_W    = 5;
    localparam int MC_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   ALUop = '0;
    logic [FUNC_W-1:0] function_code = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] ALU_control_signal;
    logic              illegal;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] sb_q[$];

    alu_control_pipe #(
        .OP_W(OP_W), .FUNC_W(FUNC_W), .CTRL_W(CTRL_W), .MC_CYCLES(MC_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALUop(ALUop),
        .function_code(function_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALU_control_signal(ALU_control_signal),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, returns {illegal, code}.
    function automatic logic [5:0] model(input logic [2:0] op, input logic [4:0] f);
        int base;
        int n;
        int idx;
        int ones;
        logic ill;
        base = 0;
        n = 0;
        idx = 0;
        ones = 0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        ill = 1'b1;
`else
        ill = 1'b0;
`endif
        case (op)
            3'd0: return 6'd0;
            3'd1: begin base = 1;  n = 5; end
            3'd2: begin base = 6;  n = 3; end
            3'd3: begin base = 9;  n = 3; end
            3'd4: begin base = 12; n = 2; end
            3'd5: begin base = 14; n = 3; end
            3'd6: return 6'd17;
            default: return 6'd18;
        endcase
        for (int i = 0; i < 5; i++) begin
            if (f[i]) begin
                ones++;
                idx = i;
            end
        end
        if (ones == 1 && idx < n) return {1'b0, 5'(base + idx)};
        return {ill, 5'd0};
    endfunction

    // One clock: settle, score both handshakes, advance, check hold stability.
    task automatic tick(output bit acc);
        bit outf;
        bit held;
        logic [5:0] e;
        logic [5:0] saved;
        #1;
        acc   = in_valid && in_ready;
        outf  = out_valid && out_ready;
        held  = out_valid && !out_ready;
        saved = {illegal, ALU_control_signal};
        if (outf) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("code", 32'(ALU_control_signal), 32'(e[4:0]));
                chk("illegal", 32'(illegal), 32'(e[5]));
            end
        end
        if (acc) sb_q.push_back(model(ALUop, function_code));
        @(posedge clk);
        #1;
        if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({illegal, ALU_control_signal}), 32'(saved));
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] f);
        bit done;
        bit a;
        done = 1'b0;
        ALUop = op;
        function_code = f;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            tick(a);
            done = a;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    bit a;

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(ALU_control_signal), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single-cycle decode: 001 / 01000 -> 4, latency 1
        out_ready = 1'b1;
        send(3'b001, 5'b01000);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_code", 32'(ALU_control_signal), 32'd4);
        chk("lat1_illegal", 32'(illegal), 32'd0);
        tick(a);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_code_kept", 32'(ALU_control_signal), 32'd4);

        // Multi-cycle op: in_ready low for MC_CYCLES-1 cycles then code 18
        send(3'b111, 5'b00000);
        for (int i = 0; i < MC_CYCLES - 1; i++) begin
            chk("multi_in_ready", 32'(in_ready), 32'd0);
            chk("multi_out_valid", 32'(out_valid), 32'd0);
            tick(a);
        end
        chk("multi_done_valid", 32'(out_valid), 32'd1);
        chk("multi_done_code", 32'(ALU_control_signal), 32'd18);
        tick(a);

        // Non-one-hot function code under class 010
        send(3'b010, 5'b00011);
        chk("bad_func_code", 32'(ALU_control_signal), 32'd0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        chk("bad_func_illegal", 32'(illegal), 32'd1);
`else
        chk("bad_func_illegal", 32'(illegal), 32'd0);
`endif
        tick(a);
        send(3'b001, 5'b00000);
        chk("zero_func_code", 32'(ALU_control_signal), 32'd0);
        tick(a);

        // Back-to-back 5, 6, 17 with no bubbles
        in_valid = 1'b1;
        ALUop = 3'b001; function_code = 5'b10000;
        #1; chk("b2b_rdy0", 32'(in_ready), 32'd1);
        tick(a);
        chk("b2b_ov0", 32'(out_valid), 32'd1);
        ALUop = 3'b010; function_code = 5'b00001;
        #1; chk("b2b_rdy1", 32'(in_ready), 32'd1);
        tick(a);
        chk("b2b_ov1", 32'(out_valid), 32'd1);
        chk("b2b_code1", 32'(ALU_control_signal), 32'd6);
        ALUop = 3'b110; function_code = 5'b10101;
        #1; chk("b2b_rdy2", 32'(in_ready), 32'd1);
        tick(a);
        chk("b2b_ov2", 32'(out_valid), 32'd1);
        chk("b2b_code2", 32'(ALU_control_signal), 32'd17);
        in_valid = 1'b0;
        tick(a);
        chk("b2b_end_valid", 32'(out_valid), 32'd0);

        // Backpressure: held result stays put, new request waits
        out_ready = 1'b0;
        send(3'b011, 5'b00100);
        ALUop = 3'b100; function_code = 5'b00010;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick(a);
            chk("bp_no_accept", 32'(a), 32'd0);
        end
        chk("bp_code", 32'(ALU_control_signal), 32'd11);
        out_ready = 1'b1;
        #1; chk("bp_release_rdy", 32'(in_ready), 32'd1);
        tick(a);
        chk("bp_release_acc", 32'(a), 32'd1);
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_code", 32'(ALU_control_signal), 32'd13);
        tick(a);

        // Reset during the second MULTI cycle
        send(3'b111, 5'b00000);
        tick(a);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_code", 32'(ALU_control_signal), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(3'b101, 5'b00100);
        chk("post_rst_code", 32'(ALU_control_signal), 32'd16);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        tick(a);

        // Random traffic through the scoreboard
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ALUop     = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                function_code = 5'(1 << $urandom_range(0, 4));
            else
                function_code = 5'($urandom);
            tick(a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (MC_CYCLES + 4) tick(a);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control_pipe.md
ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

Interface
REQ-001 Parameter OP_W, default 3, ALUop width; SHALL be >= 3, and bits above [2:0] SHALL be zero for any non-no-op decode.
REQ-002 Parameter FUNC_W, default 5, function-code width; SHALL be >= 5, and bits above [4:0] SHALL be zero for any match.
REQ-003 Parameter CTRL_W, default 5, control-signal width; SHALL be >= 5; codes are zero-extended to CTRL_W.
REQ-004 Parameter MC_CYCLES, default 4, latency in cycles of multi-cycle class ALUop 3'b111; SHALL be >= 1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  request present on ALUop/function_code.
REQ-008 in_ready  output  1  block accepts a request this cycle.
REQ-009 ALUop  input  OP_W  operation class from control unit.
REQ-010 function_code  input  FUNC_W  one-hot function field.
REQ-011 out_valid  output  1  ALU_control_signal holds a decoded result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 ALU_control_signal  output  CTRL_W  registered decoded control code.
REQ-014 illegal  output  1  registered flag: the held result came from an unlisted encoding.

Function
REQ-015 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; the result transfers out where out_valid and out_ready are both 1.
REQ-016 Decode SHALL be: 000->0; 001 with func bit0..4 -> 1..5; 010 bit0..2 -> 6..8; 011 bit0..2 -> 9..11; 100 bit0..1 -> 12,13; 101 bit0..2 -> 14..16; 110 -> 17 for any func; 111 -> 18 for any func.
REQ-017 A function code that is not exactly one listed one-hot value under classes 001-101 SHALL decode to 0 and is illegal; 000, 110 and 111 are never illegal.
REQ-018 The FSM SHALL have states IDLE (output empty), HOLD (result valid) and MULTI (multi-cycle countdown).
REQ-019 IDLE: in_ready=1; accepting a non-111 op -> HOLD with the result visible the next cycle (latency 1); accepting 111 -> MULTI with the counter loaded to MC_CYCLES-1.
REQ-020 MULTI: in_ready=0 and out_valid=0; the counter decrements each cycle; at 0 the state becomes HOLD with code 18; MC_CYCLES=1 SHALL behave as a normal op.
REQ-021 HOLD: out_valid=1; in_ready = out_ready; a simultaneous out and in transfer SHALL load the new result (non-111) or enter MULTI (111) with no bubble; out_ready=1 with no input -> IDLE.
REQ-022 ALU_control_signal and illegal SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Inputs SHALL be ignored whenever in_ready=0, even if in_valid=1.
REQ-024 The outputs SHALL hold their last value when the FSM returns to IDLE; consumers qualify them with out_valid.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, out_valid=0, ALU_control_signal=0 and illegal=0, including mid-MULTI; the aborted request is discarded.
REQ-026 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first edge after release.

Configuration
REQ-027 Macro ALU_CTRL_ILLEGAL_TRAP_EN: when it is defined, illegal is generated per REQ-017 and an illegal result does not release HOLD until it is consumed; when it is undefined, illegal is tied to 0 and illegal encodings decode silently to 0.

Verification
REQ-028 ALUop=001, func=01000, out_ready=1 -> one cycle later out_valid=1, ALU_control_signal=4, illegal=0.
REQ-029 ALUop=111, MC_CYCLES=4 -> in_ready=0 for 3 cycles, then out_valid=1 with code 18.
REQ-030 ALUop=010, func=00011 with trap enabled -> code 0, illegal=1; with the macro undefined -> code 0, illegal=0.
REQ-031 Back-to-back codes 5,6,17 with out_ready=1 -> three consecutive out_valid cycles, no bubbles.
REQ-032 out_ready=0 for 5 cycles during HOLD -> output stable and in_ready=0; release -> the next request is accepted that cycle.
REQ-033 rst_n asserted during the second MULTI cycle -> out_valid=0 and code 0 immediately; first request after release decodes normally.
